// File: rtl/wb_stage_pkg.sv
// Shared widths and debug-FSM state encoding for the write-back stage.
package wb_stage_pkg;
    localparam int REG_IDX_W = 3;
    localparam int DATA_W    = 64;
    localparam int REG_COUNT = 8;
    localparam int RD_PORTS  = 3;

    typedef enum logic [1:0] {
        DBG_IDLE    = 2'd0,
        DBG_CAPTURE = 2'd1,
        DBG_ACK     = 2'd2
    } dbg_state_t;
endpackage

// File: rtl/wb_regfile.sv
// 8 x 64 register file: r0 hard-wired to zero, combinational reads.
// Define WB_BYPASS_EN to forward same-cycle write data to matching reads.
module wb_regfile
    import wb_stage_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_we,
    input  logic [REG_IDX_W-1:0]                 i_waddr,
    input  logic [DATA_W-1:0]                    i_wdata,
    input  logic [RD_PORTS-1:0][REG_IDX_W-1:0]   i_raddr,
    output logic [RD_PORTS-1:0][DATA_W-1:0]      o_rdata
);
    logic [DATA_W-1:0] r_regs [REG_COUNT];

    genvar gi;
    // r0 is never written, so it reads zero without any read-side masking.
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_regs[gi] <= '0;
                end else if ((gi != 0) && i_we && (i_waddr == REG_IDX_W'(gi))) begin
                    r_regs[gi] <= i_wdata;
                end
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
`ifdef WB_BYPASS_EN
            logic w_hit;
            assign w_hit = i_we && (i_raddr[gi] != '0) && (i_raddr[gi] == i_waddr);
            assign o_rdata[gi] = w_hit ? i_wdata : r_regs[i_raddr[gi]];
`else
            assign o_rdata[gi] = r_regs[i_raddr[gi]];
`endif
        end
    endgenerate
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: write-data select, retire counter and debug read FSM.
// WB_BYPASS_EN (in wb_regfile) also makes the debug capture see same-cycle writes.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 NOOP_WB,
    input  logic                 ADDI_WB,
    input  logic                 MOVI_WB,
    input  logic                 LW_WB,
    input  logic                 SW_WB,
    input  logic                 SUBI_WB,
    input  logic                 WRE_WB,
    input  logic [DATA_W-1:0]    D_out_WB,
    input  logic [DATA_W-1:0]    ALU_result_WB,
    input  logic [DATA_W-1:0]    Offset_WB,
    input  logic [REG_IDX_W-1:0] rt_WB,
    input  logic [REG_IDX_W-1:0] rs_addr_ID,
    input  logic [REG_IDX_W-1:0] rt_addr_ID,
    output logic [DATA_W-1:0]    rs_data_ID,
    output logic [DATA_W-1:0]    rt_data_ID,
    input  logic                 dbg_req,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic                 dbg_ack,
    output logic [DATA_W-1:0]    dbg_data,
    output logic [31:0]          retire_cnt
);
    logic                               w_wr_en;
    logic [DATA_W-1:0]                  w_wdata;
    logic                               w_retire;
    logic [RD_PORTS-1:0][DATA_W-1:0]    w_rdata;
    logic                               w_unused_noop;

    dbg_state_t           r_state;
    logic [REG_IDX_W-1:0] r_dbg_addr;
    logic [DATA_W-1:0]    r_dbg_data;
    logic                 r_dbg_ack;
    logic [31:0]          r_retire_cnt;

    // A NOOP retires nothing and writes nothing; the flag carries no information here.
    assign w_unused_noop = NOOP_WB;

    assign w_wr_en  = WRE_WB && (LW_WB || MOVI_WB || ADDI_WB || SUBI_WB);
    assign w_wdata  = LW_WB   ? D_out_WB :
                      MOVI_WB ? Offset_WB : ALU_result_WB;
    assign w_retire = ADDI_WB || MOVI_WB || LW_WB || SW_WB || SUBI_WB;

    wb_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_en),
        .i_waddr (rt_WB),
        .i_wdata (w_wdata),
        .i_raddr ({r_dbg_addr, rt_addr_ID, rs_addr_ID}),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (w_retire && (r_retire_cnt != 32'hFFFF_FFFF)) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= DBG_IDLE;
            r_dbg_addr <= '0;
            r_dbg_data <= '0;
            r_dbg_ack  <= 1'b0;
        end else begin
            case (r_state)
                DBG_IDLE: begin
                    if (dbg_req) begin
                        r_dbg_addr <= dbg_addr;
                        r_state    <= DBG_CAPTURE;
                    end
                end
                DBG_CAPTURE: begin
                    r_dbg_data <= w_rdata[2];
                    r_dbg_ack  <= 1'b1;
                    r_state    <= DBG_ACK;
                end
                DBG_ACK: begin
                    if (!dbg_req) begin
                        r_dbg_ack <= 1'b0;
                        r_state   <= DBG_IDLE;
                    end
                end
                default: r_state <= DBG_IDLE;
            endcase
        end
    end

    assign rs_data_ID = w_rdata[0];
    assign rt_data_ID = w_rdata[1];
    assign dbg_ack    = r_dbg_ack;
    assign dbg_data   = r_dbg_data;
    assign retire_cnt = r_retire_cnt;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// against an architectural register-file model.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        NOOP_WB, ADDI_WB, MOVI_WB, LW_WB, SW_WB, SUBI_WB, WRE_WB;
    logic [63:0] D_out_WB, ALU_result_WB, Offset_WB;
    logic [2:0]  rt_WB, rs_addr_ID, rt_addr_ID, dbg_addr;
    logic [63:0] rs_data_ID, rt_data_ID, dbg_data;
    logic        dbg_req, dbg_ack;
    logic [31:0] retire_cnt;

    logic [63:0] m_regs [8];
    logic [31:0] m_cnt;
    int          total = 0;
    int          bad   = 0;

    wb_stage dut (
        .clk(clk), .rst(rst),
        .NOOP_WB(NOOP_WB), .ADDI_WB(ADDI_WB), .MOVI_WB(MOVI_WB),
        .LW_WB(LW_WB), .SW_WB(SW_WB), .SUBI_WB(SUBI_WB), .WRE_WB(WRE_WB),
        .D_out_WB(D_out_WB), .ALU_result_WB(ALU_result_WB), .Offset_WB(Offset_WB),
        .rt_WB(rt_WB), .rs_addr_ID(rs_addr_ID), .rt_addr_ID(rt_addr_ID),
        .rs_data_ID(rs_data_ID), .rt_data_ID(rt_data_ID),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack),
        .dbg_data(dbg_data), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic m_wr();
        return WRE_WB && (LW_WB || MOVI_WB || ADDI_WB || SUBI_WB) && (rt_WB != 3'd0);
    endfunction

    function automatic logic [63:0] m_wdata();
        if (LW_WB)   return D_out_WB;
        if (MOVI_WB) return Offset_WB;
        return ALU_result_WB;
    endfunction

    function automatic logic [63:0] m_read(input logic [2:0] a);
        if (a == 3'd0) return 64'd0;
`ifdef WB_BYPASS_EN
        if (m_wr() && (a == rt_WB)) return m_wdata();
`endif
        return m_regs[a];
    endfunction

    task automatic clear_in();
        NOOP_WB = 0; ADDI_WB = 0; MOVI_WB = 0; LW_WB = 0; SW_WB = 0; SUBI_WB = 0;
        WRE_WB = 0; D_out_WB = '0; ALU_result_WB = '0; Offset_WB = '0; rt_WB = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_cnt = '0;
    endtask

    // Inputs are driven at negedge; the model commits at the posedge the DUT sees.
    task automatic tick();
        @(posedge clk);
        if (m_wr()) m_regs[rt_WB] = m_wdata();
        if ((LW_WB || MOVI_WB || ADDI_WB || SUBI_WB || SW_WB) && (m_cnt != 32'hFFFF_FFFF))
            m_cnt = m_cnt + 32'd1;
        @(negedge clk);
    endtask

    task automatic write_movi(input logic [2:0] r, input logic [63:0] v);
        clear_in(); MOVI_WB = 1; WRE_WB = 1; rt_WB = r; Offset_WB = v;
        tick();
        clear_in();
    endtask

    task automatic test_reset();
        rst = 1; dbg_req = 0; dbg_addr = 0; rs_addr_ID = 0; rt_addr_ID = 0;
        clear_in(); model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h want=0", retire_cnt); end
        total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", dbg_ack); end
        total++; if (dbg_data !== 64'd0) begin bad++; $display("FAIL reset_dbg_data got=%h want=0", dbg_data); end
        for (int i = 0; i < 8; i++) begin
            rs_addr_ID = 3'(i); #1;
            total++; if (rs_data_ID !== 64'd0) begin bad++; $display("FAIL reset_reg%0d got=%h want=0", i, rs_data_ID); end
        end
        @(negedge clk);
    endtask

    task automatic test_load();
        clear_in(); LW_WB = 1; WRE_WB = 1; rt_WB = 3; D_out_WB = 64'hDEAD_BEEF;
        tick();
        clear_in(); rs_addr_ID = 3; #1;
        total++; if (rs_data_ID !== 64'hDEAD_BEEF) begin bad++; $display("FAIL load_r3 got=%h want=deadbeef", rs_data_ID); end
        total++; if (retire_cnt !== 32'd1) begin bad++; $display("FAIL load_cnt got=%0d want=1", retire_cnt); end
    endtask

    task automatic test_priority();
        clear_in(); LW_WB = 1; MOVI_WB = 1; WRE_WB = 1; D_out_WB = 5; Offset_WB = 9; rt_WB = 2;
        tick();
        clear_in(); ADDI_WB = 1; WRE_WB = 1; rt_WB = 0; ALU_result_WB = 7;
        tick();
        clear_in(); rs_addr_ID = 2; rt_addr_ID = 0; #1;
        total++; if (rs_data_ID !== 64'd5) begin bad++; $display("FAIL prio_r2 got=%h want=5", rs_data_ID); end
        total++; if (rt_data_ID !== 64'd0) begin bad++; $display("FAIL r0_zero got=%h want=0", rt_data_ID); end
    endtask

    task automatic test_bypass();
        logic [63:0] exp_same;
`ifdef WB_BYPASS_EN
        exp_same = 64'h10;
`else
        exp_same = 64'h0;
`endif
        clear_in(); ADDI_WB = 1; WRE_WB = 1; ALU_result_WB = 64'h10; rt_WB = 4; rt_addr_ID = 4; #1;
        total++; if (rt_data_ID !== exp_same) begin bad++; $display("FAIL bypass_same got=%h want=%h", rt_data_ID, exp_same); end
        tick();
        clear_in(); #1;
        total++; if (rt_data_ID !== 64'h10) begin bad++; $display("FAIL bypass_next got=%h want=10", rt_data_ID); end
    endtask

    task automatic test_noop_sw();
        logic [31:0] c0;
        write_movi(1, 64'hAA);
        c0 = retire_cnt;
        NOOP_WB = 1; WRE_WB = 1; rt_WB = 1; ALU_result_WB = 64'h55; D_out_WB = 64'h66; Offset_WB = 64'h77;
        tick();
        rs_addr_ID = 1; #1;
        total++; if (rs_data_ID !== 64'hAA) begin bad++; $display("FAIL noop_r1 got=%h want=aa", rs_data_ID); end
        total++; if (retire_cnt !== c0) begin bad++; $display("FAIL noop_cnt got=%0d want=%0d", retire_cnt, c0); end
        NOOP_WB = 0; SW_WB = 1;
        tick();
        clear_in(); #1;
        total++; if (rs_data_ID !== 64'hAA) begin bad++; $display("FAIL sw_r1 got=%h want=aa", rs_data_ID); end
        total++; if (retire_cnt !== c0 + 32'd1) begin bad++; $display("FAIL sw_cnt got=%0d want=%0d", retire_cnt, c0 + 32'd1); end
    endtask

    task automatic test_debug();
        write_movi(5, 64'h1234);
        dbg_req = 1; dbg_addr = 5;
        tick();
        total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL dbg_capture_ack got=%b want=0", dbg_ack); end
        dbg_addr = 2;
        tick();
        total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL dbg_ack got=%b want=1", dbg_ack); end
        total++; if (dbg_data !== 64'h1234) begin bad++; $display("FAIL dbg_data got=%h want=1234", dbg_data); end
        tick();
        total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL dbg_hold got=%b want=1", dbg_ack); end
        dbg_req = 0;
        tick();
        total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL dbg_release got=%b want=0", dbg_ack); end
        total++; if (dbg_data !== 64'h1234) begin bad++; $display("FAIL dbg_keep got=%h want=1234", dbg_data); end
    endtask

    task automatic test_debug_bypass();
        logic [63:0] exp_cap;
`ifdef WB_BYPASS_EN
        exp_cap = 64'h7777;
`else
        exp_cap = 64'h6666;
`endif
        write_movi(6, 64'h6666);
        dbg_req = 1; dbg_addr = 6;
        tick();
        MOVI_WB = 1; WRE_WB = 1; rt_WB = 6; Offset_WB = 64'h7777;
        tick();
        clear_in();
        total++; if (dbg_data !== exp_cap) begin bad++; $display("FAIL dbg_bypass got=%h want=%h", dbg_data, exp_cap); end
        dbg_req = 0;
        tick();
    endtask

    task automatic test_random();
        int op;
        for (int n = 0; n < 80; n++) begin
            clear_in();
            op = int'($urandom_range(0, 6));
            case (op)
                1: NOOP_WB = 1;
                2: ADDI_WB = 1;
                3: MOVI_WB = 1;
                4: LW_WB   = 1;
                5: SW_WB   = 1;
                6: SUBI_WB = 1;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) MOVI_WB = 1;
            WRE_WB        = ($urandom_range(0, 3) != 0);
            rt_WB         = 3'($urandom_range(0, 7));
            D_out_WB      = {$urandom, $urandom};
            ALU_result_WB = {$urandom, $urandom};
            Offset_WB     = {$urandom, $urandom};
            rs_addr_ID    = 3'($urandom_range(0, 7));
            rt_addr_ID    = ($urandom_range(0, 1) == 1) ? rt_WB : 3'($urandom_range(0, 7));
            #1;
            total++; if (rs_data_ID !== m_read(rs_addr_ID)) begin bad++; $display("FAIL rand_rs n=%0d got=%h want=%h", n, rs_data_ID, m_read(rs_addr_ID)); end
            total++; if (rt_data_ID !== m_read(rt_addr_ID)) begin bad++; $display("FAIL rand_rt n=%0d got=%h want=%h", n, rt_data_ID, m_read(rt_addr_ID)); end
            $display("txn %0d op=%0d wre=%b rt=%0d rs_addr=%0d rt_addr=%0d", n, op, WRE_WB, rt_WB, rs_addr_ID, rt_addr_ID);
            tick();
            total++; if (retire_cnt !== m_cnt) begin bad++; $display("FAIL rand_cnt n=%0d got=%0d want=%0d", n, retire_cnt, m_cnt); end
        end
        clear_in();
    endtask

    task automatic test_reset_ack();
        write_movi(5, 64'h1234);
        dbg_req = 1; dbg_addr = 5; rs_addr_ID = 5;
        tick();
        tick();
        total++; if (dbg_ack !== 1'b1 || dbg_data !== 64'h1234) begin bad++; $display("FAIL pre_reset_ack ack=%b data=%h want ack=1 data=1234", dbg_ack, dbg_data); end
        #2 rst = 1;
        #1;
        model_reset();
        total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL async_ack got=%b want=0", dbg_ack); end
        total++; if (dbg_data !== 64'd0) begin bad++; $display("FAIL async_data got=%h want=0", dbg_data); end
        total++; if (rs_data_ID !== 64'd0) begin bad++; $display("FAIL async_r5 got=%h want=0", rs_data_ID); end
        total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL async_cnt got=%h want=0", retire_cnt); end
        @(negedge clk);
        rst = 0;
        tick();
        tick();
        total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL post_reset_capture got=%b want=1", dbg_ack); end
        total++; if (dbg_data !== 64'd0) begin bad++; $display("FAIL post_reset_data got=%h want=0", dbg_data); end
        dbg_req = 0;
        tick();
    endtask

    task automatic test_saturation();
        dut.r_retire_cnt = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        clear_in(); ADDI_WB = 1; WRE_WB = 1; rt_WB = 7; ALU_result_WB = 64'h1;
        tick();
        total++; if (retire_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_reach got=%h want=ffffffff", retire_cnt); end
        tick();
        total++; if (retire_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffffffff", retire_cnt); end
        clear_in();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_priority();
        test_bypass();
        test_noop_sw();
        test_debug();
        test_debug_bypass();
        test_random();
        test_reset_ack();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
